sys_mem_agent_arb: RTL and testbench

//  Round-robin arbiter sharing the system memory controller between NUM_AGENTS requesters.

---
 rtl/sys_mem_agent_arb.sv | 188 ++++++++++++++++++
 tb/tb_sys_mem_agent_arb.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_mem_agent_arb.sv
`timescale 1ns/1ps
// Round-robin arbiter in front of the memory controller: partition lookup, bounds check, one command in flight.
// Request to mem_cmd_valid in PART_LAT+2 cycles; the command is held until ready, and agent_gnt_o stays high until mem_done_i.
module sys_mem_agent_arb #(
    parameter int MEM_ADDR_W = 27,
    parameter int NUM_AGENTS = 2,
    parameter int BLEN_W     = 8,
    parameter int PART_LAT   = 2,
    localparam int AGENT_ID_W = $clog2(NUM_AGENTS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_AGENTS-1:0]            agent_req_i,
    input  logic [NUM_AGENTS-1:0]            agent_wr_i,
    input  logic [NUM_AGENTS*MEM_ADDR_W-1:0] agent_offset_i,
    input  logic [NUM_AGENTS*BLEN_W-1:0]     agent_blen_i,
    output logic [NUM_AGENTS-1:0]            agent_gnt_o,
    output logic [NUM_AGENTS-1:0]            agent_err_o,
    output logic [AGENT_ID_W-1:0]            part_agent_id_o,
    input  logic [MEM_ADDR_W-1:0]            part_start_addr_i,
    input  logic [MEM_ADDR_W-1:0]            part_end_addr_i,
    output logic                             mem_cmd_valid_o,
    input  logic                             mem_cmd_ready_i,
    output logic                             mem_cmd_wr_o,
    output logic [MEM_ADDR_W-1:0]            mem_cmd_addr_o,
    output logic [BLEN_W-1:0]                mem_cmd_blen_o,
    input  logic                             mem_done_i
);

    localparam int AW1   = MEM_ADDR_W + 1;
    localparam int CNT_W = (PART_LAT > 1) ? $clog2(PART_LAT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_CHECK, S_ISSUE, S_BUSY} state_t;

    state_t                  state_q, state_d;
    logic [AGENT_ID_W-1:0]   sel_q, sel_d, rr_q, rr_d;
    logic                    wr_q, wr_d;
    logic [MEM_ADDR_W-1:0]   off_q, off_d;
    logic [BLEN_W-1:0]       blen_q, blen_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_AGENTS-1:0]   gnt_q, gnt_d, err_q, err_d;
    logic                    valid_q, valid_d, cwr_q, cwr_d;
    logic [MEM_ADDR_W-1:0]   caddr_q, caddr_d;
    logic [BLEN_W-1:0]       cblen_q, cblen_d;

    logic                    pick_vld;
    logic [AGENT_ID_W-1:0]   pick_id, scan_id;
    logic [MEM_ADDR_W-1:0]   off_pick;
    logic [BLEN_W-1:0]       blen_pick;
    logic [AW1-1:0]          abs_w, last_w;
    logic                    chk_err, req_sel;

    function automatic logic [AGENT_ID_W-1:0] inc_id(input logic [AGENT_ID_W-1:0] id);
        return (id == AGENT_ID_W'(NUM_AGENTS - 1)) ? '0 : id + AGENT_ID_W'(1);
    endfunction

    // First requester at or after the RR pointer, with wrap.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        scan_id  = rr_q;
        for (int i = 0; i < NUM_AGENTS; i++) begin
            if (!pick_vld && agent_req_i[scan_id]) begin
                pick_vld = 1'b1;
                pick_id  = scan_id;
            end
            scan_id = inc_id(scan_id);
        end
    end

    assign off_pick  = MEM_ADDR_W'(agent_offset_i >> (int'(pick_id) * MEM_ADDR_W));
    assign blen_pick = BLEN_W'(agent_blen_i >> (int'(pick_id) * BLEN_W));
    assign req_sel   = agent_req_i[sel_q];

    // One extra bit so a burst running past the top of memory shows up as a carry.
    assign abs_w   = AW1'(part_start_addr_i) + AW1'(off_q);
    assign last_w  = abs_w + AW1'(blen_q) - AW1'(1);
    assign chk_err = (blen_q == '0) || abs_w[MEM_ADDR_W] || last_w[MEM_ADDR_W]
                     || (last_w[MEM_ADDR_W-1:0] > part_end_addr_i);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        wr_d    = wr_q;
        off_d   = off_q;
        blen_d  = blen_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        err_d   = '0;
        valid_d = valid_q;
        cwr_d   = cwr_q;
        caddr_d = caddr_q;
        cblen_d = cblen_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    sel_d   = pick_id;
                    wr_d    = agent_wr_i[pick_id];
                    off_d   = off_pick;
                    blen_d  = blen_pick;
                    cnt_d   = '0;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!req_sel)                              state_d = S_IDLE;
                else if (cnt_q == CNT_W'(PART_LAT - 1))    state_d = S_CHECK;
                else                                       cnt_d   = cnt_q + CNT_W'(1);
            end
            S_CHECK: begin
                if (!req_sel) begin
                    state_d = S_IDLE;
                end else if (chk_err) begin
                    err_d[sel_q] = 1'b1;
                    rr_d         = inc_id(sel_q);
                    state_d      = S_IDLE;
                end else begin
                    valid_d = 1'b1;
                    cwr_d   = wr_q;
                    caddr_d = abs_w[MEM_ADDR_W-1:0];
                    cblen_d = blen_q;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A handshake in the same cycle as a dropped request still commits the burst.
                if (mem_cmd_ready_i) begin
                    valid_d      = 1'b0;
                    gnt_d[sel_q] = 1'b1;
                    state_d      = S_BUSY;
                end else if (!req_sel) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (mem_done_i) begin
                    gnt_d   = '0;
                    rr_d    = inc_id(sel_q);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            rr_q    <= '0;
            wr_q    <= 1'b0;
            off_q   <= '0;
            blen_q  <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            err_q   <= '0;
            valid_q <= 1'b0;
            cwr_q   <= 1'b0;
            caddr_q <= '0;
            cblen_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            wr_q    <= wr_d;
            off_q   <= off_d;
            blen_q  <= blen_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            cwr_q   <= cwr_d;
            caddr_q <= caddr_d;
            cblen_q <= cblen_d;
        end
    end

    assign agent_gnt_o     = gnt_q;
    assign agent_err_o     = err_q;
    assign part_agent_id_o = sel_q;
    assign mem_cmd_valid_o = valid_q;
    assign mem_cmd_wr_o    = cwr_q;
    assign mem_cmd_addr_o  = caddr_q;
    assign mem_cmd_blen_o  = cblen_q;

endmodule

// File: tb/tb_sys_mem_agent_arb.sv
`timescale 1ns/1ps
// Scoreboard bench for sys_mem_agent_arb: directed bursts push expected commands/errors, a monitor pops them.
module tb_sys_mem_agent_arb;

    localparam int AW = 27;
    localparam int N  = 2;
    localparam int BW = 8;
    localparam int PL = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0, wr_v = '0;
    logic [AW-1:0]   off_a [N];
    logic [BW-1:0]   blen_a [N];
    logic [N*AW-1:0] off_p;
    logic [N*BW-1:0] blen_p;
    logic [N-1:0]    gnt, err;
    logic [0:0]      part_id;
    logic [AW-1:0]   pstart, pend;
    logic            valid, ready = 1'b1, cwr, done = 1'b0;
    logic [AW-1:0]   caddr;
    logic [BW-1:0]   cblen;

    always #5 clk = ~clk;

    always_comb begin
        off_p  = '0;
        blen_p = '0;
        for (int k = 0; k < N; k++) begin
            off_p[k*AW +: AW]  = off_a[k];
            blen_p[k*BW +: BW] = blen_a[k];
        end
    end

    sys_mem_agent_arb #(.MEM_ADDR_W(AW), .NUM_AGENTS(N), .BLEN_W(BW), .PART_LAT(PL)) dut (
        .clk(clk), .rst_n(rst_n),
        .agent_req_i(req), .agent_wr_i(wr_v), .agent_offset_i(off_p), .agent_blen_i(blen_p),
        .agent_gnt_o(gnt), .agent_err_o(err), .part_agent_id_o(part_id),
        .part_start_addr_i(pstart), .part_end_addr_i(pend),
        .mem_cmd_valid_o(valid), .mem_cmd_ready_i(ready), .mem_cmd_wr_o(cwr),
        .mem_cmd_addr_o(caddr), .mem_cmd_blen_o(cblen), .mem_done_i(done)
    );

    // Partition manager model: table lookup behind a PART_LAT-deep pipeline.
    logic [AW-1:0] st_tbl [N];
    logic [AW-1:0] en_tbl [N];
    logic [0:0]    p1 = '0, p2 = '0;
    always @(posedge clk) begin
        p1 <= part_id;
        p2 <= p1;
    end
    assign pstart = st_tbl[p2];
    assign pend   = en_tbl[p2];

    typedef struct packed {
        logic          is_err;
        logic [0:0]    agent;
        logic          wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] blen;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_vec = 0, n_err = 0, n_hs = 0, bcnt = 0;
    logic [N-1:0] mon_pg = '0;
    logic         mon_pd = 1'b0, mon_phs = 1'b0, mon_hs = 1'b0;
    logic [0:0]   mon_last = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_cmd(input logic [0:0] a, input logic w, input logic [AW-1:0] ad, input logic [BW-1:0] b);
        q.push_back(exp_t'{1'b0, a, w, ad, b});
    endtask

    task automatic push_err(input logic [0:0] a);
        q.push_back(exp_t'{1'b1, a, 1'b0, {AW{1'b0}}, {BW{1'b0}}});
    endtask

    // Monitor: every handshake and every err pulse must match the head of the queue.
    initial begin
        forever begin
            @(negedge clk);
            mon_hs = 1'b0;
            if (rst_n) begin
                if (valid && ready) begin
                    n_hs++;
                    mon_hs   = 1'b1;
                    mon_last = part_id;
                    if (q.size() == 0) chk("cmd_unexpected", {caddr, cblen}, 0);
                    else begin
                        e = q.pop_front();
                        chk("cmd", {1'b0, part_id, cwr, caddr, cblen}, e);
                    end
                end
                if (err != '0) begin
                    if (q.size() == 0) chk("err_unexpected", err, 0);
                    else begin
                        e = q.pop_front();
                        chk("err", {1'b1, err}, {e.is_err, 2'b01 << e.agent});
                    end
                end
                if (mon_pg == '0 && gnt != '0) chk("gnt_rise", {mon_phs, gnt}, {1'b1, 2'b01 << mon_last});
                if (mon_pg != '0 && gnt == '0) chk("gnt_hold_until_done", mon_pd, 1);
            end
            mon_pg  = gnt;
            mon_pd  = done;
            mon_phs = mon_hs;
        end
    end

    // Controller model: mem_done pulses on the third cycle of a grant.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (done) done = 1'b0;
            else if (gnt != '0 && rst_n) begin
                bcnt++;
                if (bcnt == 3) begin
                    done = 1'b1;
                    bcnt = 0;
                end
            end else bcnt = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_agent(input int a, input logic w, input logic [AW-1:0] o, input logic [BW-1:0] b);
        wr_v[a]   = w;
        off_a[a]  = o;
        blen_a[a] = b;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && (gnt != '0 || valid); i++) step();
        chk("idle_timeout", {gnt, valid}, 0);
        step();
    endtask

    task automatic run_one(input int a);
        int i;
        req[a] = 1'b1;
        for (i = 0; i < 100; i++) begin
            step();
            if (gnt[a] || err[a]) break;
        end
        chk("resp_timeout", i < 100, 1);
        req[a] = 1'b0;
        wait_idle();
    endtask

    task automatic hold_all(input int n);
        int i;
        int target;
        target = n_hs + n;
        for (i = 0; i < 500; i++) begin
            step();
            if (n_hs >= target && gnt != '0) break;
        end
        chk("hold_timeout", i < 500, 1);
        req = '0;
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int i;
        st_tbl[0] = 27'h0;    en_tbl[0] = 27'hFFF;
        st_tbl[1] = 27'h1000; en_tbl[1] = 27'h1FFF;
        for (int k = 0; k < N; k++) set_agent(k, 1'b0, '0, '0);
        step(); step();
        chk("reset_outputs", {gnt, err, part_id, valid, cwr, caddr, cblen}, 0);
        rst_n = 1'b1;
        step();

        // Single agent1 burst and its latency.
        set_agent(1, 1'b1, 27'h10, 8'd4);
        push_cmd(1, 1'b1, 27'h1010, 8'd4);
        req[1] = 1'b1;
        step(); step(); step();
        chk("latency_c3_valid", valid, 0);
        step();
        chk("latency_c4_valid", valid, 1);
        for (i = 0; i < 50 && !gnt[1]; i++) step();
        chk("t1_gnt", gnt, 2'b10);
        req[1] = 1'b0;
        wait_idle();

        // Partition bounds.
        set_agent(1, 1'b0, 27'hFFC, 8'd4); push_cmd(1, 1'b0, 27'h1FFC, 8'd4); run_one(1);
        set_agent(1, 1'b0, 27'hFFD, 8'd4); push_err(1); run_one(1);
        set_agent(1, 1'b1, 27'h10, 8'd0);  push_err(1); run_one(1);

        // Fairness: both requesting continuously.
        set_agent(0, 1'b1, 27'h100, 8'd8);
        set_agent(1, 1'b0, 27'h20, 8'd2);
        for (int k = 0; k < 4; k++) begin
            push_cmd(0, 1'b1, 27'h100, 8'd8);
            push_cmd(1, 1'b0, 27'h1020, 8'd2);
        end
        req = 2'b11;
        hold_all(8);

        // Backpressure on the command channel.
        ready = 1'b0;
        set_agent(0, 1'b1, 27'h40, 8'd16);
        push_cmd(0, 1'b1, 27'h40, 8'd16);
        req[0] = 1'b1;
        for (i = 0; i < 20; i++) begin
            step();
            if (valid) break;
        end
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold", {valid, cwr, caddr, cblen, gnt}, {1'b1, 1'b1, 27'h40, 8'd16, 2'b00});
            step();
        end
        ready = 1'b1;
        for (i = 0; i < 20 && !gnt[0]; i++) step();
        chk("bp_gnt", gnt, 2'b01);
        req[0] = 1'b0;
        wait_idle();
        set_agent(1, 1'b1, 27'h0, 8'd1); push_cmd(1, 1'b1, 27'h1000, 8'd1); run_one(1);

        // Abandon in LOOKUP; pointer stays where it was.
        set_agent(0, 1'b0, 27'h8, 8'd2);
        set_agent(1, 1'b0, 27'h30, 8'd3);
        push_cmd(1, 1'b0, 27'h1030, 8'd3);
        req = 2'b11;
        step();
        req[0] = 1'b0;
        hold_all(1);
        req[0] = 1'b1;
        step();
        req[0] = 1'b0;
        step();
        push_cmd(0, 1'b0, 27'h8, 8'd2);
        push_cmd(1, 1'b0, 27'h1030, 8'd3);
        req = 2'b11;
        hold_all(2);

        // Top-of-memory partition: carry out of the address width.
        st_tbl[0] = 27'h7FFFFF0; en_tbl[0] = 27'h7FFFFFF;
        set_agent(0, 1'b0, 27'h20, 8'd1); push_err(0); run_one(0);
        set_agent(0, 1'b1, 27'h8, 8'd8);  push_cmd(0, 1'b1, 27'h7FFFFF8, 8'd8); run_one(0);
        set_agent(0, 1'b0, 27'h9, 8'd8);  push_err(0); run_one(0);
        st_tbl[0] = 27'h0; en_tbl[0] = 27'hFFF;

        // Reset while a burst is granted.
        set_agent(1, 1'b0, 27'h100, 8'd5);
        push_cmd(1, 1'b0, 27'h1100, 8'd5);
        req[1] = 1'b1;
        for (i = 0; i < 50 && !gnt[1]; i++) step();
        chk("pre_reset_gnt", gnt, 2'b10);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_in_busy", {gnt, err, part_id, valid, cwr, caddr, cblen}, 0);
        req = '0;
        step(); step();
        rst_n = 1'b1;
        step();
        set_agent(0, 1'b0, 27'h4, 8'd1);
        set_agent(1, 1'b0, 27'h4, 8'd1);
        push_cmd(0, 1'b0, 27'h4, 8'd1);
        push_cmd(1, 1'b0, 27'h1004, 8'd1);
        req = 2'b11;
        hold_all(2);

        step(); step();
        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
